// File: rtl/veririsc_controller.sv
// veririsc_controller: 8-phase instruction sequencer for the VeriRISC datapath.
// Decodes the IR opcode against the current phase into the datapath strobes.
// The halt latch freezes the phase counter until reset.
// Ports:
//   clk, rst_n       - clock, async active-low reset
//   en               - phase advance enable (0 freezes phase, halted and outputs)
//   opcode[2:0]      - IR opcode (0 HLT,1 SKZ,2 ADD,3 AND,4 XOR,5 LDA,6 STO,7 JMP)
//   zero             - ALU accumulator-zero flag
//   sel              - memory address source (1 = PC, 0 = IR operand)
//   rd, wr           - memory read/write strobes
//   ld_ir, ld_ac     - instruction register / accumulator loads
//   ld_pc, inc_pc    - PC load (jump) / PC increment
//   data_e           - drive AC onto data bus
//   halt             - halt indication (sticky)
//   phase[2:0]       - current phase
module veririsc_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       halt,
  output logic       ld_pc,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr,
  output logic [2:0] phase
);

  localparam int unsigned OPW = 3;
  localparam int unsigned PHW = 3;

  localparam logic [OPW-1:0] OP_HLT = OPW'(0);
  localparam logic [OPW-1:0] OP_SKZ = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_AND = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_LDA = OPW'(5);
  localparam logic [OPW-1:0] OP_STO = OPW'(6);
  localparam logic [OPW-1:0] OP_JMP = OPW'(7);

  typedef enum logic [PHW-1:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  phase_e r_phase;
  phase_e w_phase_nxt;
  logic   r_halted;
  logic   w_halted_nxt;

  logic   w_aluop;
  logic   w_is_hlt;
  logic   w_is_skz;
  logic   w_is_sto;
  logic   w_is_jmp;

  // Opcode class terms
  assign w_aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);
  assign w_is_hlt = (opcode == OP_HLT);
  assign w_is_skz = (opcode == OP_SKZ);
  assign w_is_sto = (opcode == OP_STO);
  assign w_is_jmp = (opcode == OP_JMP);

  assign phase = r_phase;

  // State register: phase counter and halt latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase  <= PH_INST_ADDR;
      r_halted <= 1'b0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    w_phase_nxt  = r_phase;
    w_halted_nxt = r_halted;
    sel          = 1'b0;
    rd           = 1'b0;
    ld_ir        = 1'b0;
    inc_pc       = 1'b0;
    halt         = 1'b0;
    ld_pc        = 1'b0;
    data_e       = 1'b0;
    ld_ac        = 1'b0;
    wr           = 1'b0;

    // HLT in OP_ADDR still advances to OP_FETCH on the same edge it latches
    if (en && !r_halted) begin
      w_phase_nxt = phase_e'(PHW'(r_phase) + PHW'(1));
      if (r_phase == PH_OP_ADDR && w_is_hlt) begin
        w_halted_nxt = 1'b1;
      end
    end

    case (r_phase)
      PH_INST_ADDR: begin
        sel = 1'b1;
      end
      PH_INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      PH_INST_LOAD, PH_IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      PH_OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = w_is_hlt;
      end
      PH_OP_FETCH: begin
        rd = w_aluop;
      end
      PH_ALU_OP: begin
        rd     = w_aluop;
        inc_pc = w_is_skz && zero;
        ld_pc  = w_is_jmp;
        data_e = w_is_sto;
      end
      PH_STORE: begin
        rd     = w_aluop;
        ld_ac  = w_aluop;
        ld_pc  = w_is_jmp;
        inc_pc = w_is_jmp;
        wr     = w_is_sto;
        data_e = w_is_sto;
      end
      default: begin
        sel = 1'b0;
      end
    endcase

    // Once halted only sel (from the frozen phase) survives; halt is forced high
    if (r_halted) begin
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      data_e = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      halt   = 1'b1;
    end
  end

endmodule

// File: tb/tb_veririsc_controller.sv
// Scoreboard bench for veririsc_controller: stimulus pushes hand-computed
// expected output vectors, a monitor process pops and compares them.
// Vector layout: {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr,phase[2:0]}
module tb_veririsc_controller;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
  logic [2:0] phase;

  veririsc_controller dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .halt   (halt),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .phase  (phase)
  );

  typedef struct {
    string       name;
    logic [11:0] v;
  } exp_t;

  exp_t exp_q[$];
  event ev_chk;
  int   n_cmp;
  int   n_bad;

  // Common fetch phases 0..3 (opcode independent)
  localparam logic [11:0] V_P0   = 12'b1_0_0_0_0_0_0_0_0_000;
  localparam logic [11:0] V_P1   = 12'b1_1_0_0_0_0_0_0_0_001;
  localparam logic [11:0] V_P2   = 12'b1_1_1_0_0_0_0_0_0_010;
  localparam logic [11:0] V_P3   = 12'b1_1_1_0_0_0_0_0_0_011;
  localparam logic [11:0] V_P4   = 12'b0_0_0_1_0_0_0_0_0_100;
  // ALU-class opcodes (ADD/LDA)
  localparam logic [11:0] V_A5   = 12'b0_1_0_0_0_0_0_0_0_101;
  localparam logic [11:0] V_A6   = 12'b0_1_0_0_0_0_0_0_0_110;
  localparam logic [11:0] V_A7   = 12'b0_1_0_0_0_0_0_1_0_111;
  // Quiet phases for non-ALU opcodes
  localparam logic [11:0] V_Q5   = 12'b0_0_0_0_0_0_0_0_0_101;
  localparam logic [11:0] V_Q6   = 12'b0_0_0_0_0_0_0_0_0_110;
  localparam logic [11:0] V_Q7   = 12'b0_0_0_0_0_0_0_0_0_111;
  // SKZ with zero=1 at ALU_OP
  localparam logic [11:0] V_SK6  = 12'b0_0_0_1_0_0_0_0_0_110;
  // STO
  localparam logic [11:0] V_ST6  = 12'b0_0_0_0_0_0_1_0_0_110;
  localparam logic [11:0] V_ST7  = 12'b0_0_0_0_0_0_1_0_1_111;
  // JMP
  localparam logic [11:0] V_JM6  = 12'b0_0_0_0_0_1_0_0_0_110;
  localparam logic [11:0] V_JM7  = 12'b0_0_0_1_0_1_0_0_0_111;
  // HLT
  localparam logic [11:0] V_H4   = 12'b0_0_0_1_1_0_0_0_0_100;
  localparam logic [11:0] V_H5   = 12'b0_0_0_0_1_0_0_0_0_101;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against the live outputs
  initial begin
    forever begin
      @(ev_chk);
      while (exp_q.size() > 0) begin
        exp_t        e;
        logic [11:0] got;
        e   = exp_q.pop_front();
        got = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, phase};
        n_cmp++;
        if (got !== e.v) begin
          n_bad++;
          $display("FAIL %s: got %b required %b", e.name, got, e.v);
        end
      end
    end
  end

  task automatic check(input string name, input logic [11:0] v);
    exp_t e;
    e.name = name;
    e.v    = v;
    exp_q.push_back(e);
    -> ev_chk;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Run one full instruction from phase 0, checking each phase, ending at phase 0
  task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                           input logic [11:0] e4, input logic [11:0] e5,
                           input logic [11:0] e6, input logic [11:0] e7);
    logic [11:0] ex [8];
    opcode = op;
    zero   = z;
    ex[0] = V_P0; ex[1] = V_P1; ex[2] = V_P2; ex[3] = V_P3;
    ex[4] = e4;   ex[5] = e5;   ex[6] = e6;   ex[7] = e7;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_ph%0d", tag, i), ex[i]);
      tick();
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    opcode = 3'd2;
    zero   = 1'b0;

    #12;
    check("reset_state", V_P0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    // ADD walk through all phases, then wrap to 0
    run_instr("add", 3'd2, 1'b0, V_P4, V_A5, V_A6, V_A7);
    check("add_wrap", V_P0);

    // SKZ taken / not taken; zero high outside ALU_OP has no effect on ph7
    run_instr("skz_z1", 3'd1, 1'b1, V_P4, V_Q5, V_SK6, V_Q7);
    run_instr("skz_z0", 3'd1, 1'b0, V_P4, V_Q5, V_Q6, V_Q7);

    // STO and JMP
    run_instr("sto", 3'd6, 1'b0, V_P4, V_Q5, V_ST6, V_ST7);
    run_instr("jmp", 3'd7, 1'b0, V_P4, V_Q5, V_JM6, V_JM7);

    // LDA with an en stall at OP_FETCH
    opcode = 3'd5;
    for (int i = 0; i < 5; i++) tick();
    check("lda_ph5", V_A5);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("lda_stall%0d", i), V_A5);
    end
    en = 1'b1;
    tick();
    check("lda_ph6", V_A6);
    tick();
    check("lda_ph7", V_A7);
    tick();
    check("lda_wrap", V_P0);

    // HLT: latch at OP_ADDR, freeze at phase 5 even with an ALU opcode presented
    opcode = 3'd0;
    for (int i = 0; i < 4; i++) tick();
    check("hlt_ph4", V_H4);
    tick();
    check("hlt_ph5", V_H5);
    opcode = 3'd2;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("hlt_frozen%0d", i), V_H5);
    end
    rst_n = 1'b0;
    #1;
    check("hlt_reset", V_P0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("hlt_restart_ph1", V_P1);
    tick(); tick(); tick();

    // Async reset between edges while JMP is in ALU_OP
    opcode = 3'd7;
    tick(); tick();
    check("async_ph6", V_JM6);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", V_P0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("async_restart_ph1", V_P1);

    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
